// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: pulls words out of a FIFO read port (registered read data,
// valid the cycle after rinc) and presents them as a valid/ready stream through
// a 2-entry skid buffer, sustaining one word per cycle.
//
// State table
//   IDLE  | fetching disabled, buffer empty, nothing in flight
//   RUN   | fetching allowed while enable=1 and the buffer has credit
//   DRAIN | enable dropped: no new reads, finish the in-flight word and buffered words
//
// Optional feature: define FIFO_RD_STREAMER_CNT_EN to add the 16-bit rd_cnt
// output counting delivered words (wraps at 0xFFFF).
module fifo_rd_streamer #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             enable,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy
`ifdef FIFO_RD_STREAMER_CNT_EN
  ,
  output logic [15:0]      rd_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [DSIZE-1:0] buf_head;
  logic [DSIZE-1:0] buf_tail;
  logic [1:0]       occ;
  logic             inflight;
  logic             pop;
  logic             has_credit;

  // credit = 2 - occ - inflight + pop; credit >= 1 rewritten without negatives.
  assign pop        = m_valid & m_ready;
  assign has_credit = ({1'b0, occ} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});
  assign rinc       = (state == RUN) & enable & ~rempty & has_credit;
  assign m_valid    = (occ != 2'd0);
  assign m_data     = buf_head;
  assign busy       = (state != IDLE);

  // Sequencing: follow enable and wait for the buffer to empty before idling.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) state <= ((occ != 2'd0) || inflight) ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (enable)                            state <= RUN;
          else if ((occ == 2'd0) && !inflight)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: capture the word read last cycle, shift on pop, keep FIFO order.
  // The head only changes on a pop or while empty, so m_data holds under backpressure.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      inflight <= rinc;
      unique case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf_head <= rdata;
          else             buf_tail <= rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= rdata;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_STREAMER_CNT_EN
  // Delivered-word counter, free-running wrap.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rd_cnt <= 16'h0000;
    else if (pop) rd_cnt <= rd_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Testbench for fifo_rd_streamer: a queue-based FIFO model with registered read
// data feeds the DUT; a scoreboard queue holds every word written to the FIFO in
// order and each stream transfer must match its front.
module tb_fifo_rd_streamer;

  logic       rclk;
  logic       rrst_n;
  logic [7:0] rdata;
  logic       rempty;
  logic       rinc;
  logic       enable;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
`ifdef FIFO_RD_STREAMER_CNT_EN
  logic [15:0] rd_cnt;
`endif

  fifo_rd_streamer #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rdata   (rdata),
    .rempty  (rempty),
    .rinc    (rinc),
    .enable  (enable),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy)
`ifdef FIFO_RD_STREAMER_CNT_EN
    ,
    .rd_cnt  (rd_cnt)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_errors;
  int         n_pop;
  int         cyc;
  int         sample_cyc;
  logic       s_valid, s_rinc, s_busy, s_pop;
  logic       prev_v, prev_r;
  logic [7:0] prev_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    rempty = 1'b0;
  endtask

  // Per-cycle protocol and ordering checks, sampled mid-cycle.
  task automatic monitor();
    if (s_rinc) begin
      chk("rinc_while_empty", {31'b0, rempty}, 0);
      chk("rinc_without_enable", {31'b0, enable}, 1);
    end
    if (prev_v && !prev_r) begin
      chk("hold_valid", {31'b0, m_valid}, 1);
      chk("hold_data", {24'b0, m_data}, {24'b0, prev_d});
    end
    if (s_pop) begin
      if (exp_q.size() == 0) chk("pop_unexpected", exp_q.size(), 1);
      else chk("pop_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
      n_pop++;
    end
    prev_v = m_valid;
    prev_r = m_ready;
    prev_d = m_data;
  endtask

  // One clock: sample at negedge, model the FIFO's registered read after posedge.
  task automatic tick();
    logic rd_now;
    @(negedge rclk);
    sample_cyc = cyc;
    s_valid = m_valid;
    s_rinc  = rinc;
    s_busy  = busy;
    s_pop   = m_valid & m_ready;
    rd_now  = rinc;
    if (rrst_n) monitor();
    else prev_v = 1'b0;
    @(posedge rclk);
    #1;
    cyc++;
    if (rd_now) begin
      if (fifo_q.size() == 0) chk("fifo_underflow", fifo_q.size(), 1);
      else rdata = fifo_q.pop_front();
    end
    rempty = (fifo_q.size() == 0);
  endtask

  task automatic reset_dut();
    rrst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    rempty = 1'b1;
    n_pop = 0;
    prev_v = 1'b0;
    repeat (2) tick();
    rrst_n = 1'b1;
    tick();
  endtask

  task automatic flush(input string tag);
    enable = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) begin
      if (i > 4 && exp_q.size() == 0) enable = 1'b0;
      tick();
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int rinc_n, val_n, rinc_cyc, val_cyc, push_cyc;
    int first, last, cnt, base, pushed, k;
    n_checks = 0; n_errors = 0; n_pop = 0; cyc = 0;
    rrst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = 8'h00;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
    s_valid = 0; s_rinc = 0; s_busy = 0; s_pop = 0; sample_cyc = 0;

    // Reset state
    #2;
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_rinc", {31'b0, rinc}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_m_data", {24'b0, m_data}, 0);
`ifdef FIFO_RD_STREAMER_CNT_EN
    chk("rst_rd_cnt", {16'b0, rd_cnt}, 0);
`endif
    reset_dut();

    // Single word with latency
    enable = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    push(8'hA5);
    push_cyc = cyc;
    rinc_n = 0; val_n = 0; rinc_cyc = -100; val_cyc = -100;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_rinc)  begin rinc_n++; rinc_cyc = sample_cyc; end
      if (s_valid) begin val_n++;  val_cyc  = sample_cyc; end
    end
    chk("single_rinc_pulses", rinc_n, 1);
    chk("single_valid_cycles", val_n, 1);
    chk("first_rinc_latency", rinc_cyc - push_cyc, 0);
    chk("first_valid_latency", val_cyc - rinc_cyc, 2);
    chk("single_rinc_idle", {31'b0, s_rinc}, 0);
    chk("single_rempty", {31'b0, rempty}, 1);
    chk("single_delivered", exp_q.size(), 0);

    // Streaming 16 words back to back
    for (int i = 0; i < 16; i++) push(i[7:0]);
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_valid) begin
        if (first < 0) first = sample_cyc;
        last = sample_cyc;
        cnt++;
      end
    end
    chk("stream_count", cnt, 16);
    chk("stream_no_gaps", last - first, 15);
    chk("stream_delivered", exp_q.size(), 0);

    // Backpressure mid-stream
    base = n_pop;
    for (int i = 0; i < 20; i++) push(8'h40 + i[7:0]);
    repeat (4) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2) chk("bp_rinc_low", {31'b0, s_rinc}, 0);
      chk("bp_valid_held", {31'b0, s_valid}, 1);
    end
    m_ready = 1'b1;
    repeat (40) tick();
    chk("bp_words_delivered", n_pop - base, 20);
    chk("bp_scoreboard_empty", exp_q.size(), 0);

    // Drain with a full buffer
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h80 + i[7:0]);
    repeat (6) tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("drain_rinc_low", {31'b0, s_rinc}, 0);
      chk("drain_busy", {31'b0, s_busy}, 1);
    end
    base = n_pop;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("drain_rinc_low2", {31'b0, s_rinc}, 0);
    end
    chk("drain_words", n_pop - base, 2);
    chk("drain_idle_busy", {31'b0, busy}, 0);
    chk("drain_fifo_left", fifo_q.size(), 4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) push(8'($urandom));
      tick();
    end
    flush("random_all_delivered");
`ifdef FIFO_RD_STREAMER_CNT_EN
    chk("random_rd_cnt", {16'b0, rd_cnt}, n_pop & 32'hFFFF);
`endif

    // Reset mid-stream with one word buffered
    enable = 1'b1; m_ready = 1'b0;
    push(8'h5A);
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    chk("pre_reset_valid", {31'b0, m_valid}, 1);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", {31'b0, m_valid}, 0);
    chk("mid_rst_rinc", {31'b0, rinc}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_m_data", {24'b0, m_data}, 0);
    fifo_q.delete(); exp_q.delete(); rempty = 1'b1; n_pop = 0; prev_v = 1'b0;
    tick();
    push(8'h3C);
    tick();
    rrst_n = 1'b1;
    tick();
    chk("post_rst_rinc_low", {31'b0, s_rinc}, 0);
    chk("post_rst_idle", {31'b0, s_busy}, 0);
    tick();
    chk("post_rst_rinc", {31'b0, s_rinc}, 1);
    flush("post_rst_delivered");

`ifdef FIFO_RD_STREAMER_CNT_EN
    // Counter wrap: 65537 deliveries
    reset_dut();
    chk("cnt_after_reset", {16'b0, rd_cnt}, 0);
    enable = 1'b1; m_ready = 1'b1;
    pushed = 0; k = 0;
    while (n_pop < 65537 && k < 70000) begin
      if (fifo_q.size() < 8 && pushed < 65537) begin
        push(8'(pushed));
        pushed++;
      end
      tick();
      k++;
    end
    chk("cnt_words", n_pop, 65537);
    repeat (3) tick();
    chk("cnt_wrap", {16'b0, rd_cnt}, 32'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
